sig_mwi: RTL and testbench

SIG_MWI -- requirements
Module: sig_mwi

---
 rtl/sig_mwi_pkg.sv | 8 +
 rtl/sig_mwi_buf.sv | 38 +++
 rtl/sig_mwi.sv | 80 ++++++++
 tb/tb_sig_mwi.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sig_mwi_pkg.sv
// Shared signal-chain constants: sample width, default averaging window and
// the widths derived from them.
package sig_mwi_pkg;
    localparam int SIG_DW  = 9;
    localparam int MWI_WIN = 32;
    localparam int MWI_LW  = $clog2(MWI_WIN);
    localparam int MWI_SW  = SIG_DW + MWI_LW;
endpackage

// File: rtl/sig_mwi_buf.sv
// Circular sample buffer for the moving-window integrator. The entry under the
// write pointer is the oldest sample, so it is read and overwritten together.
module sig_mwi_buf
    import sig_mwi_pkg::*;
#(
    parameter int WIN = MWI_WIN,
    parameter int DW  = SIG_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          wrap_o
);
    localparam int LW = $clog2(WIN);

    logic [WIN-1:0][DW-1:0] mem_q;
    logic [LW-1:0]          ptr_q;

    assign rdata_o = mem_q[ptr_q];
    assign wrap_o  = we_i && (ptr_q == LW'(WIN - 1));

    // WIN is a power of two, so the pointer wraps by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            ptr_q <= '0;
        end else if (clr_i) begin
            mem_q <= '0;
            ptr_q <= '0;
        end else if (we_i) begin
            mem_q[ptr_q] <= wdata_i;
            ptr_q        <= ptr_q + 1'b1;
        end
    end
endmodule

// File: rtl/sig_mwi.sv
// Moving-window integrator: running sum over the last WIN rectified samples,
// averaged by shift, two-cycle latency from accepted sample to result.
module sig_mwi
    import sig_mwi_pkg::*;
#(
    parameter int WIN = MWI_WIN,
    parameter int DW  = SIG_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [DW-1:0] data,
    output logic          out_valid,
    output logic [DW-1:0] result,
    output logic          primed
);
    localparam int LW = $clog2(WIN);
    localparam int SW = DW + LW;
    localparam int FW = LW + 1;

    logic          acc;
    logic [DW-1:0] oldest;
    logic          wrap;
    logic [SW-1:0] sum_q, sum_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [2:1]    vld_pipe_q;
    logic [DW-1:0] result_q;
    logic          primed_q;

    // A clear wins over a sample presented in the same cycle.
    assign acc = in_valid && !clr;

    sig_mwi_buf #(.WIN(WIN), .DW(DW)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .we_i    (acc),
        .wdata_i (data),
        .rdata_o (oldest),
        .wrap_o  (wrap)
    );

    always_comb begin
        sum_d  = sum_q;
        fill_d = fill_q;
        if (acc) begin
            sum_d = sum_q + SW'(data) - SW'(oldest);
            // First wrap of the pointer is exactly the WIN-th sample.
            if (fill_q != FW'(WIN))
                fill_d = wrap ? FW'(WIN) : fill_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q      <= '0;
            fill_q     <= '0;
            vld_pipe_q <= '0;
            result_q   <= '0;
            primed_q   <= 1'b0;
        end else if (clr) begin
            sum_q      <= '0;
            fill_q     <= '0;
            vld_pipe_q <= '0;
            primed_q   <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            fill_q     <= fill_d;
            vld_pipe_q <= {vld_pipe_q[1], acc};
            if (vld_pipe_q[1])
                result_q <= sum_q[SW-1:LW];
            primed_q   <= (fill_q == FW'(WIN));
        end
    end

    assign out_valid = vld_pipe_q[2];
    assign result    = result_q;
    assign primed    = primed_q;
endmodule

// File: tb/tb_sig_mwi.sv
// Scoreboard bench for sig_mwi: the driver pushes the expected average for each
// sample once it is sure the sample survives, the monitor pops on out_valid.
module tb_sig_mwi;
    localparam int DW  = 9;
    localparam int WIN = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] data = '0;
    logic          out_valid;
    logic [DW-1:0] result;
    logic          primed;

    always #5 clk = ~clk;

    sig_mwi #(.WIN(WIN), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .data      (data),
        .out_valid (out_valid),
        .result    (result),
        .primed    (primed)
    );

    typedef struct {
        int res;
        bit pr;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   hist[$];
    int   nacc = 0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   pend_v = 1'b0;
    exp_t pend;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A sample's expectation is queued one cycle late, so a clr that drops
    // its stage-2 result can cancel it before it reaches the scoreboard.
    task automatic drive(input bit v, input int d, input bit c);
        int s;
        @(posedge clk);
        #1;
        if (pend_v && !c) sb.push_back(pend);
        pend_v   = 1'b0;
        in_valid = v;
        data     = DW'(d);
        clr      = c;
        if (c) begin
            hist.delete();
            nacc = 0;
        end else if (v) begin
            hist.push_back(d);
            if (hist.size() > WIN) void'(hist.pop_front());
            if (nacc < WIN) nacc++;
            s = 0;
            foreach (hist[i]) s += hist[i];
            pend.res = s / WIN;
            pend.pr  = (nacc >= WIN);
            pend.cyc = cyc + 2;
            pend_v   = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
    endtask

    // Reset lands one edge after the last sample was captured; its result dies.
    task automatic reset_mid();
        @(posedge clk);
        #1;
        pend_v   = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clr      = 1'b0;
        hist.delete();
        nacc = 0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_primed", int'(primed), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        int   last_res;
        last_res = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_res = 0;
            end else begin
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    chk("missing_out_valid", 0, 1);
                end
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("result", int'(result), e.res);
                        chk("primed", int'(primed), int'(e.pr));
                        chk("latency_cycle", cyc, e.cyc);
                        last_res = e.res;
                    end
                end else begin
                    chk("result_hold", int'(result), last_res);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not end, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin : stim
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_result", int'(result), 0);
        chk("reset_primed", int'(primed), 0);
        rst_n = 1'b1;

        // constant 100: 3,6,9,... then 100 with primed on the 32nd
        for (int i = 0; i < 40; i++) drive(1'b1, 100, 1'b0);
        idle(3);
        drive(1'b0, 0, 1'b1);

        // full-scale magnitude, sum peaks at 8192
        for (int i = 0; i < 32; i++) drive(1'b1, 256, 1'b0);
        idle(3);
        drive(1'b0, 0, 1'b1);

        // impulse: 2 for 32 outputs, then 0 after wrap
        drive(1'b1, 64, 1'b0);
        for (int i = 0; i < 40; i++) drive(1'b1, 0, 1'b0);
        idle(3);
        drive(1'b0, 0, 1'b1);

        // gapped valid with junk data on idle cycles
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32, 1'b0);
            drive(1'b0, 511, 1'b0);
        end
        idle(3);
        drive(1'b0, 0, 1'b1);

        // clr together with in_valid mid-stream
        for (int i = 0; i < 20; i++) drive(1'b1, 100, 1'b0);
        drive(1'b1, 100, 1'b1);
        drive(1'b1, 64, 1'b0);
        idle(4);

        // reset one cycle after a sample
        drive(1'b1, 50, 1'b0);
        reset_mid();
        idle(5);
        drive(1'b1, 96, 1'b0);
        idle(4);

        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
